// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory master.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MEM_SIZE_BYTE = 1'b0;
    localparam logic MEM_SIZE_WORD = 1'b1;

    function automatic logic [3:0] byte_sel(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane extraction and sign extension of Wishbone read data for loads.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] dat,
    input  logic [1:0]            lane,
    input  logic                  size,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = dat[8*lane +: 8];
        if (size == MEM_SIZE_WORD)
            data = dat;
        else
            data = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage Wishbone-classic master; one bus cycle per load/store.
// Define MEM_ALIGN_CHECK_EN to trap misaligned word accesses instead of forcing alignment.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall_req,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misalign_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]            wb_sel_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("mem_access_unit supports DATA_WIDTH=32 only");
        end
    endgenerate

    state_t state;
    state_t next;

    logic                  req;
    logic                  word;
    logic                  misaligned;
    logic [1:0]            lane;
    logic                  size;
    logic [DATA_WIDTH-1:0] aligned;

    assign req  = mem_read | mem_write;
    assign word = (mem_size == MEM_SIZE_WORD);

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign;

    assign misaligned = word & (|addr[1:0]);
    assign misalign_o = misalign;

    // Flag lives only in the DONE cycle that follows the trapped request.
    always_ff @(posedge clk) begin
        if (!reset)
            misalign <= 1'b0;
        else
            misalign <= (state == IDLE) && req && misaligned;
    end
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (req)
                    next = misaligned ? DONE : BUS;
            end
            BUS: begin
                if (wb_ack_i)
                    next = DONE;
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        wb_cyc_o  = 1'b0;
        stall_req = 1'b0;
        unique case (state)
            IDLE:    stall_req = req;
            BUS: begin
                wb_cyc_o  = 1'b1;
                stall_req = 1'b1;
            end
            DONE:    stall_req = 1'b0;
            default: stall_req = 1'b0;
        endcase
        if (!reset)
            stall_req = 1'b0;
        wb_stb_o = wb_cyc_o;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= 4'b0000;
            lane      <= 2'b00;
            size      <= MEM_SIZE_BYTE;
            load_data <= '0;
        end else begin
            if (state == IDLE && req) begin
                if (misaligned) begin
                    load_data <= '0;
                end else begin
                    wb_we_o <= mem_write;
                    lane    <= addr[1:0];
                    size    <= mem_size;
                    if (word) begin
                        wb_adr_o <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        wb_dat_o <= wdata;
                        wb_sel_o <= 4'b1111;
                    end else begin
                        wb_adr_o <= addr;
                        wb_dat_o <= {4{wdata[7:0]}};
                        wb_sel_o <= byte_sel(addr[1:0]);
                    end
                end
            end
            if (state == BUS && wb_ack_i)
                load_data <= aligned;
        end
    end

    mem_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .dat  (wb_dat_i),
        .lane (lane),
        .size (size),
        .data (aligned)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        mem_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall_req;
    logic [31:0] load_data;
    logic        misalign_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .addr       (addr),
        .wdata      (wdata),
        .stall_req  (stall_req),
        .load_data  (load_data),
        .misalign_o (misalign_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        mem_read = 1'b1;
        mem_size = 1'b1;
        addr     = 32'h0000_0100;
        tick();
        tick();
        #1;
        total++;
        if (stall_req !== 1'b0)
            $display("FAIL reset_stall: got %b want 0", stall_req);
        else passed++;
        total++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000)
            $display("FAIL reset_cyc_stb_we: got %b want 000",
                     {wb_cyc_o, wb_stb_o, wb_we_o});
        else passed++;
        total++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0)
            $display("FAIL reset_adr_dat_sel: got %h %h %h want 0",
                     wb_adr_o, wb_dat_o, wb_sel_o);
        else passed++;
        total++;
        if (load_data !== 32'h0 || misalign_o !== 1'b0)
            $display("FAIL reset_load_mis: got %h %b want 0 0",
                     load_data, misalign_o);
        else passed++;
        mem_read = 1'b0;
        reset    = 1'b1;
        tick();
    endtask

    task automatic test_word_load;
        int stalls;
        mem_read = 1'b1;
        mem_size = 1'b1;
        addr     = 32'h8000_0104;
        #1;
        stalls = int'(stall_req);
        tick();
        mem_read = 1'b0;
        #1;
        stalls += int'(stall_req);
        total++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110)
            $display("FAIL wl_cyc_stb_we: got %b want 110",
                     {wb_cyc_o, wb_stb_o, wb_we_o});
        else passed++;
        total++;
        if (wb_sel_o !== 4'b1111 || wb_adr_o !== 32'h8000_0104)
            $display("FAIL wl_sel_adr: got %b %h want 1111 80000104",
                     wb_sel_o, wb_adr_o);
        else passed++;
        tick();
        stalls += int'(stall_req);
        tick();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        #1;
        stalls += int'(stall_req);
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        #1;
        stalls += int'(stall_req);
        total++;
        if (stalls != 4)
            $display("FAIL wl_stall_cycles: got %0d want 4", stalls);
        else passed++;
        total++;
        if (wb_cyc_o !== 1'b0 || load_data !== 32'hDEAD_BEEF)
            $display("FAIL wl_done: got cyc %b data %h want 0 deadbeef",
                     wb_cyc_o, load_data);
        else passed++;
        tick();
        total++;
        if (load_data !== 32'hDEAD_BEEF)
            $display("FAIL wl_hold: got %h want deadbeef", load_data);
        else passed++;
    endtask

    task automatic test_byte_store;
        mem_write = 1'b1;
        mem_size  = 1'b0;
        addr      = 32'h8000_0003;
        wdata     = 32'h0000_00A5;
        tick();
        mem_write = 1'b0;
        #1;
        total++;
        if (wb_we_o !== 1'b1 || wb_cyc_o !== 1'b1 || wb_sel_o !== 4'b1000)
            $display("FAIL bs_we_cyc_sel: got %b %b %b want 1 1 1000",
                     wb_we_o, wb_cyc_o, wb_sel_o);
        else passed++;
        total++;
        if (wb_dat_o !== 32'hA5A5_A5A5 || wb_adr_o !== 32'h8000_0003)
            $display("FAIL bs_dat_adr: got %h %h want a5a5a5a5 80000003",
                     wb_dat_o, wb_adr_o);
        else passed++;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        #1;
        total++;
        if (stall_req !== 1'b0 || wb_cyc_o !== 1'b0)
            $display("FAIL bs_done: got stall %b cyc %b want 0 0",
                     stall_req, wb_cyc_o);
        else passed++;
        tick();
    endtask

    task automatic test_byte_load;
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [31:0] e [2];
        logic [3:0]  s [2];
        a[0] = 32'h8000_0202; d[0] = 32'h0080_0000;
        e[0] = 32'hFFFF_FF80; s[0] = 4'b0100;
        a[1] = 32'h8000_0200; d[1] = 32'h0000_007F;
        e[1] = 32'h0000_007F; s[1] = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            mem_read = 1'b1;
            mem_size = 1'b0;
            addr     = a[i];
            tick();
            mem_read = 1'b0;
            #1;
            total++;
            if (wb_sel_o !== s[i])
                $display("FAIL bl_sel%0d: got %b want %b", i, wb_sel_o, s[i]);
            else passed++;
            wb_ack_i = 1'b1;
            wb_dat_i = d[i];
            tick();
            wb_ack_i = 1'b0;
            wb_dat_i = 32'h0;
            #1;
            total++;
            if (load_data !== e[i])
                $display("FAIL bl_data%0d: got %h want %h", i, load_data, e[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_back_to_back;
        mem_read = 1'b1;
        mem_size = 1'b1;
        addr     = 32'h0000_0010;
        tick();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1111_1111;
        #1;
        total++;
        if (wb_stb_o !== 1'b1)
            $display("FAIL b2b_stb: got %b want 1", wb_stb_o);
        else passed++;
        tick();
        wb_ack_i  = 1'b0;
        wb_dat_i  = 32'h0;
        mem_write = 1'b1;
        addr      = 32'h0000_0020;
        wdata     = 32'hCAFE_F00D;
        #1;
        total++;
        if (wb_cyc_o !== 1'b0 || stall_req !== 1'b0 || load_data !== 32'h1111_1111)
            $display("FAIL b2b_done: got %b %b %h want 0 0 11111111",
                     wb_cyc_o, stall_req, load_data);
        else passed++;
        tick();
        total++;
        if (wb_cyc_o !== 1'b0 || stall_req !== 1'b1)
            $display("FAIL b2b_no_double: got cyc %b stall %b want 0 1",
                     wb_cyc_o, stall_req);
        else passed++;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        total++;
        if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 ||
            wb_adr_o !== 32'h0000_0020 || wb_dat_o !== 32'hCAFE_F00D)
            $display("FAIL b2b_second: got %b %b %h %h want 1 1 20 cafef00d",
                     wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o);
        else passed++;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_bus;
        mem_read = 1'b1;
        mem_size = 1'b1;
        addr     = 32'h0000_0040;
        tick();
        mem_read = 1'b0;
        reset    = 1'b0;
        #1;
        total++;
        if (stall_req !== 1'b0)
            $display("FAIL rmb_stall_forced: got %b want 0", stall_req);
        else passed++;
        tick();
        reset    = 1'b1;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1234_5678;
        #1;
        total++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || load_data !== 32'h0)
            $display("FAIL rmb_after_reset: got %b %b %h want 0 0 0",
                     wb_cyc_o, wb_stb_o, load_data);
        else passed++;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        #1;
        total++;
        if (load_data !== 32'h0 || wb_cyc_o !== 1'b0 || stall_req !== 1'b0)
            $display("FAIL rmb_late_ack: got %h %b %b want 0 0 0",
                     load_data, wb_cyc_o, stall_req);
        else passed++;
    endtask

    task automatic test_misalign;
        mem_read = 1'b1;
        mem_size = 1'b1;
        addr     = 32'h8000_0102;
        tick();
        mem_read = 1'b0;
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        total++;
        if (wb_cyc_o !== 1'b0 || misalign_o !== 1'b1 ||
            load_data !== 32'h0 || stall_req !== 1'b0)
            $display("FAIL mis_done: got %b %b %h %b want 0 1 0 0",
                     wb_cyc_o, misalign_o, load_data, stall_req);
        else passed++;
        tick();
        total++;
        if (misalign_o !== 1'b0 || wb_cyc_o !== 1'b0)
            $display("FAIL mis_one_cycle: got %b %b want 0 0",
                     misalign_o, wb_cyc_o);
        else passed++;
`else
        total++;
        if (wb_adr_o !== 32'h8000_0100 || wb_sel_o !== 4'b1111 ||
            wb_cyc_o !== 1'b1 || misalign_o !== 1'b0)
            $display("FAIL mis_forced: got %h %b %b %b want 80000100 1111 1 0",
                     wb_adr_o, wb_sel_o, wb_cyc_o, misalign_o);
        else passed++;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0A0B_0C0D;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        #1;
        total++;
        if (load_data !== 32'h0A0B_0C0D)
            $display("FAIL mis_data: got %h want 0a0b0c0d", load_data);
        else passed++;
        tick();
`endif
    endtask

    initial begin
        reset     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_size  = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        wb_dat_i  = 32'h0;
        wb_ack_i  = 1'b0;
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_back_to_back();
        test_reset_mid_bus();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
